// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM burst read path.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int RAM_RD_LAT = 1;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/rdr_skid_fifo.sv
// Two-entry output FIFO holding {last, data}; push and pop may coincide at any occupancy.
module rdr_skid_fifo
  import ram_rd_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end
  end

  // When full, the write slot is the slot being popped, so full+pop+push is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read controller: issues credit-limited RAM reads and streams words out with backpressure.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  rd_state_t               state, state_nxt;
  logic [ADDR_W-1:0]       addr_p0;
  logic [LEN_W-1:0]        remaining;
  logic [RAM_RD_LAT-1:0]   vld_p1;
  logic [RAM_RD_LAT-1:0]   last_p1;
  logic                    accept;
  logic                    pop;
  logic                    fifo_empty;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [DATA_W:0]         fifo_dout;
  logic [3:0]              credit;

  assign accept    = req_valid && req_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ram_addr  = addr_p0;

  // Words already held or still returning from RAM, less the one leaving this cycle.
  assign credit = 4'(fifo_count) + 4'($countones(vld_p1)) - 4'(pop);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ram_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = req_valid;
        if (req_valid) state_nxt = (req_len == '0) ? DONE : READ;
      end
      READ: begin
        busy   = 1'b1;
        ram_en = (remaining != '0) && (credit < 4'(FIFO_DEPTH));
        if (ram_en && remaining == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: address issue and burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p0   <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr_p0   <= req_addr;
      remaining <= req_len;
    end else if (ram_en) begin
      addr_p0   <= addr_p0 + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  // Stage p1: RAM read in flight; clearing it on reset discards the returning word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= '0;
      last_p1 <= '0;
    end else begin
      vld_p1  <= (vld_p1 << 1) | RAM_RD_LAT'(ram_en);
      last_p1 <= (last_p1 << 1) | RAM_RD_LAT'(ram_en && remaining == LEN_W'(1));
    end
  end

  rdr_skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1[RAM_RD_LAT-1]),
    .din   ({last_p1[RAM_RD_LAT-1], ram_rdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // FIFO storage is not reset, so idle outputs are forced to zero.
  assign out_data = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign out_last = !fifo_empty && fifo_dout[DATA_W];

endmodule
